// File: rtl/if_fetch_queue_pkg.sv
// rtl/if_fetch_queue_pkg.sv - shared constants, entry type and pc helper for the fetch queue
package if_fetch_queue_pkg;

  // Instruction width and the default first fetch address after reset.
  localparam int          INS_W       = 32;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  // One queued fetch: the pc it was fetched from and the returned instruction.
  typedef struct packed {
    logic [31:0]      pc;
    logic [INS_W-1:0] ins;
  } fetch_entry_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - redirect, IF/ID output and imem request/response bundle
interface if_fetch_queue_if;
  import if_fetch_queue_pkg::*;

  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             deq;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [INS_W-1:0] out_ins;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [INS_W-1:0] imem_rdata;

  // The fetch queue itself.
  modport slave (
    input  redirect, redirect_pc, deq, imem_gnt, imem_rvalid, imem_rdata,
    output out_valid, out_pc, out_ins, imem_req, imem_addr
  );

  // The surrounding pipeline and instruction memory.
  modport master (
    output redirect, redirect_pc, deq, imem_gnt, imem_rvalid, imem_rdata,
    input  out_valid, out_pc, out_ins, imem_req, imem_addr
  );

endinterface

// File: rtl/if_fetch_queue_fetch_fifo.sv
// rtl/if_fetch_queue_fetch_fifo.sv - DEPTH x 64 circular FIFO holding {pc, instruction} pairs
module if_fetch_queue_fetch_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic                   flush,
  input  fetch_entry_t           wr_data,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write alongside a read.
  assign do_rd = rd_en && !empty && !flush;
  assign do_wr = wr_en && !flush && (!full || do_rd);

  // Head reads as zero when empty so the IF/ID side never sees stale storage.
  assign head = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction prefetch queue between imem and the IF/ID register
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  if_fetch_queue_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] pending;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [CW-1:0] pending_after_rsp;
  logic [CW:0]   credit_used;
  logic          issue;
  logic          accept;
  logic          discard;
  logic          full;
  logic          empty;
  fetch_entry_t  wr_data;
  fetch_entry_t  head;

  // Every slot is either queued or owed by imem; never request beyond what can be stored.
  assign credit_used   = {1'b0, count} + {1'b0, pending};
  assign bus.imem_req  = !rst && !bus.redirect && (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_addr = fetch_pc;
  assign issue         = bus.imem_req && bus.imem_gnt;

  // Responses belonging to a flushed stream are counted in drop and thrown away.
  assign pending_after_rsp = pending - CW'(bus.imem_rvalid);
  assign discard           = bus.imem_rvalid && (drop != '0);
  assign accept            = bus.imem_rvalid && (drop == '0) && !bus.redirect;
  assign wr_data           = {rsp_pc, bus.imem_rdata};

  // Request/response pc counters and the outstanding/discard counters; redirect overrides all.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      pending  <= '0;
      drop     <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= align_pc(bus.redirect_pc);
      rsp_pc   <= align_pc(bus.redirect_pc);
      pending  <= pending_after_rsp;
      drop     <= pending_after_rsp;
    end else begin
      if (issue)   fetch_pc <= fetch_pc + 32'd4;
      if (accept)  rsp_pc   <= rsp_pc + 32'd4;
      if (discard) drop     <= drop - CW'(1);
      pending <= pending_after_rsp + CW'(issue);
    end
  end

  if_fetch_queue_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .rd_en   (bus.deq),
    .flush   (bus.redirect),
    .wr_data (wr_data),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign bus.out_valid = !empty;
  assign bus.out_pc    = head.pc;
  assign bus.out_ins   = head.ins;

  // Credit accounting keeps storage and discard counters in range.
  assert property (@(posedge clk) disable iff (rst)
    (credit_used <= (CW+1)'(DEPTH)) && (drop <= pending));

  // A response never lands on a full queue unless the head leaves in the same cycle.
  assert property (@(posedge clk) disable iff (rst)
    !(accept && full && !bus.deq));

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - randomized and directed checks of if_fetch_queue against a queue model
module tb_if_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic clk = 1'b0;
  logic rst;

  if_fetch_queue_if bus ();

  if_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  req_t        outst[$];
  ent_t        outq[$];
  logic [31:0] fetch_pc_m;
  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  // One clock cycle: drive at negedge, check the model's view, advance the model, cross the edge.
  task automatic step(input bit r, input bit rd, input logic [31:0] rpc, input bit dq,
                      input bit g, input bit rsp_en, input int k);
    bit   rv;
    bit   req_m;
    bit   deq_fire;
    req_t t;
    ent_t e;
    @(negedge clk);
    rv                = !r && rsp_en && (outst.size() > 0) && (outst[0].due <= cyc);
    rst               = r;
    bus.redirect      = rd;
    bus.redirect_pc   = rpc;
    bus.deq           = dq;
    bus.imem_gnt      = g;
    bus.imem_rvalid   = rv;
    bus.imem_rdata    = rv ? ins_of(outst[0].addr) : $urandom;
    #1;
    req_m     = !r && !rd && ((outq.size() + outst.size()) < DEPTH);
    obs_req   = bus.imem_req;
    obs_addr  = bus.imem_addr;
    obs_valid = bus.out_valid;
    obs_pc    = bus.out_pc;
    check("imem_req", {31'b0, bus.imem_req}, {31'b0, req_m});
    if (req_m) check("imem_addr", bus.imem_addr, fetch_pc_m);
    check("out_valid", {31'b0, bus.out_valid}, {31'b0, outq.size() > 0});
    if (outq.size() > 0) begin
      check("out_pc", bus.out_pc, outq[0].pc);
      check("out_ins", bus.out_ins, outq[0].ins);
    end
    if (r) begin
      outq.delete();
      outst.delete();
      fetch_pc_m = RESET_PC;
    end else begin
      deq_fire = dq && !rd && (outq.size() > 0);
      if (deq_fire) void'(outq.pop_front());
      if (rv) begin
        t = outst.pop_front();
        if (!t.stale && !rd) begin
          e.pc  = t.addr;
          e.ins = ins_of(t.addr);
          outq.push_back(e);
        end
      end
      if (rd) begin
        outq.delete();
        foreach (outst[i]) outst[i].stale = 1'b1;
        fetch_pc_m = rpc & 32'hFFFF_FFFC;
      end else if (req_m && g) begin
        t.addr  = fetch_pc_m;
        t.stale = 1'b0;
        t.due   = cyc + k;
        outst.push_back(t);
        fetch_pc_m = fetch_pc_m + 32'd4;
      end
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 1);
  endtask

  // Run until the head is valid, checking it is the expected pc; an expired bound is a failure.
  task automatic wait_head(input string tag, input logic [31:0] pc);
    int guard = 0;
    step(0, 0, 0, 0, 1, 1, 1);
    while (!obs_valid && guard < 30) begin
      step(0, 0, 0, 0, 1, 1, 1);
      guard++;
    end
    check({tag, "_valid"}, {31'b0, obs_valid}, 32'd1);
    check({tag, "_pc"}, obs_pc, pc);
  endtask

  // Let everything in flight return and the queue empty without issuing more.
  task automatic drain();
    int guard = 0;
    while ((outst.size() > 0 || outq.size() > 0) && guard < 40) begin
      step(0, 0, 0, 1, 0, 1, 1);
      guard++;
    end
    check("drain_done", outst.size() + outq.size(), 32'd0);
  endtask

  int issues;

  initial begin
    rst             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.deq         = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    fetch_pc_m      = RESET_PC;

    do_reset();
    do_reset();
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_ins", bus.out_ins, 32'd0);

    // Streaming from reset with one-cycle imem.
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, 1, 1, 1, 1);
      if (c < 3) check("t1_addr", obs_addr, 32'(4 * c));
      check("t1_valid", {31'b0, obs_valid}, {31'b0, c >= 2});
      if (c >= 2) check("t1_pc", obs_pc, 32'(4 * (c - 2)));
    end

    // No dequeue: credit stops after DEPTH fetches.
    do_reset();
    issues = 0;
    for (int c = 0; c < 8; c++) begin
      step(0, 0, 0, 0, 1, 1, 1);
      if (obs_req) issues++;
    end
    check("t2_issues", issues, 32'd4);
    check("t2_head", obs_pc, 32'd0);
    step(0, 0, 0, 1, 1, 1, 1);
    issues = 0;
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0, 1, 1, 1);
      if (obs_req) begin
        issues++;
        check("t2_refill_addr", obs_addr, 32'h10);
      end
    end
    check("t2_refill_issues", issues, 32'd1);

    // Reset with a full queue.
    do_reset();
    step(0, 0, 0, 0, 0, 0, 1);
    check("t6_valid", {31'b0, obs_valid}, 32'd0);
    check("t6_addr", obs_addr, RESET_PC);
    check("t6_req", {31'b0, obs_req}, 32'd1);

    // Redirect with two slow responses in flight.
    do_reset();
    step(0, 0, 0, 1, 1, 1, 3);
    step(0, 0, 0, 1, 1, 1, 3);
    step(0, 1, 32'h41, 1, 1, 1, 3);
    step(0, 0, 0, 0, 0, 1, 1);
    check("t3_addr", obs_addr, 32'h40);
    wait_head("t3", 32'h40);

    // Response, dequeue and redirect in the same cycle.
    do_reset();
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 1, 1, 1);
    for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 1, 0, 1);
    step(0, 1, 32'h200, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("t4_valid", {31'b0, obs_valid}, 32'd0);
    wait_head("t4", 32'h200);

    // Grant withheld: request and address hold.
    drain();
    step(0, 1, 32'h8, 0, 0, 1, 1);
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, 0, 0, 1, 1);
      check("t5_req", {31'b0, obs_req}, 32'd1);
      check("t5_addr", obs_addr, 32'h8);
    end

    // Address wrap at the top of memory.
    drain();
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    check("t7_wrap", obs_addr, 32'h0000_0000);
    wait_head("t7", 32'hFFFF_FFFC);

    // Back-to-back redirects: the later target wins.
    step(0, 1, 32'h300, 1, 1, 1, 2);
    step(0, 1, 32'h500, 1, 1, 1, 2);
    wait_head("b2b", 32'h500);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      step($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0, rpc,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, $urandom_range(1, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
